rf_addr_dispatcher: RTL and testbench
=====================================

Name: rf_addr_dispatcher

Overview:
- Downstream stage of the address-to-RF block.
- On that block's finish pulse, walks the produced register file (RF_DEPTH entries of three 7-bit address fields) from entry 0 to entry length-1.
- Drops null entries and streams each remaining address triple to the PE/accumulator array over a valid/ready handshake.
- Reports a done pulse and an emitted-entry count per pass.

Parameters:
- RF_DEPTH, 512, number of RF entries (the W_C_LENGTH value of the upstream block); must be at least 474.
- FIELD_W, 7, width of each address field.
- NULL_CODE, 7'h7F, a field[0] value that marks an entry as empty; that entry is skipped.
- LEN_W, $clog2(RF_DEPTH)+1, width of length and counters.

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, reset, asynchronous, active-low.
- i_finish, input, 1, one-cycle pulse from the upstream block: RF and length are valid.
- i_RF, input, [2:0][FIELD_W-1:0] x [0:RF_DEPTH-1], upstream RF; field[0]=out_x, field[1]=out_y, field[2]=weight index.
- i_length, input, LEN_W, number of RF entries to process.
- o_busy, output, 1, high from the cycle after an accepted i_finish until o_done.
- o_valid, output, 1, output triple is valid.
- i_ready, input, 1, consumer accepts the triple.
- o_x, output, FIELD_W, field[0] of the current entry.
- o_y, output, FIELD_W, field[1] of the current entry.
- o_idx, output, FIELD_W, field[2] of the current entry.
- o_done, output, 1, one-cycle pulse when the pass completes.
- o_emit_cnt, output, LEN_W, number of triples handed off in the current or last pass.

Behaviour:
- Reset values: all outputs are 0; FSM is in IDLE; ptr and len_q are 0. Reset asserted mid-pass aborts the pass immediately; no o_done is produced.
- Upstream contract: i_RF is held stable from i_finish until the next upstream start. This block reads i_RF in place and does not copy it.
- i_length is latched on an accepted i_finish as len_q = min(i_length, RF_DEPTH).
- FSM IDLE:
  - i_finish=1 sets ptr=0 and o_emit_cnt=0, latches len_q, and moves to SCAN.
  - If the latched len_q is 0, move to DONE instead.
  - i_finish in SCAN or DONE is ignored.
- FSM SCAN, per cycle:
  - The output slot is free when o_valid=0, or when o_valid & i_ready (handshake this cycle).
  - If the slot is free and ptr < len_q:
    - If i_RF[ptr][0] == NULL_CODE: ptr++ and nothing is emitted; o_valid falls if a handshake completed.
    - Otherwise: load o_x/o_y/o_idx from i_RF[ptr] and set o_valid=1 in the next cycle; ptr++.
  - If the slot is free and ptr == len_q, move to DONE with o_valid=0.
  - Each completed handshake (o_valid & i_ready) increments o_emit_cnt.
- Output holding:
  - o_valid, once high, holds with o_x/o_y/o_idx stable until i_ready.
  - i_ready while o_valid=0 has no effect.
- Throughput and latency:
  - With i_ready held high and no null entries, there is one triple per cycle.
  - The first o_valid appears 2 cycles after i_finish.
  - Each null entry costs one bubble cycle.
- FSM DONE: o_done=1 for exactly one cycle, o_busy drops in the same cycle, then return to IDLE. o_emit_cnt holds its value until the next accepted i_finish.
- o_busy is high in SCAN only.
- Width rules:
  - ptr and counters are LEN_W bits; ptr never exceeds len_q, so no wrap.
  - Fields pass through unmodified; only field[0] is decoded.
- Simultaneous events:
  - A handshake and a new load in the same cycle give back-to-back valid with no gap.
  - i_finish in the same cycle as o_done is ignored; the upstream must re-pulse it.

Test Plan:
- Dense pass:
  - Stimulus: i_length=474, entry i = {i%8, i%128, 3i%128}, i_ready=1 throughout.
  - Required: 474 consecutive valid cycles starting 2 cycles after i_finish; triples match entries 0..473 in order; o_done one cycle after the last handshake; o_emit_cnt=474.
- Null skipping:
  - Stimulus: i_length=6; entries 1 and 4 have field[0]=7'h7F.
  - Required: exactly entries 0, 2, 3, 5 are emitted, with bubbles at the skips; o_emit_cnt=4.
- Backpressure:
  - Stimulus: i_length=3; i_ready low for 5 cycles while entry 0 is presented.
  - Required: o_valid and o_x/o_y/o_idx hold stable for those 5 cycles; no entry is lost or duplicated; o_emit_cnt=3.
- Boundaries:
  - i_length=0 -> o_done pulses 1 cycle after i_finish, o_valid never rises, o_emit_cnt=0.
  - i_length=600 -> clamped; exactly 512 entries are scanned.
- Re-trigger and reset:
  - A second i_finish during SCAN is ignored; the pass completes normally.
  - i_rst_n asserted low after 10 emits -> all outputs 0 asynchronously, no o_done.
  - A new i_finish after release starts a clean pass with o_emit_cnt counting from 0.

Source files
------------

// File: rtl/rf_addr_dispatcher.sv
// rf_addr_dispatcher
// Walks the register file produced by the address-to-RF stage once per
// finish pulse, drops null entries (field[0] == NULL_CODE) and streams the
// remaining address triples to the PE/accumulator array over valid/ready.
// The RF is read in place: the upstream keeps it stable for the whole pass.

module rf_addr_dispatcher #(
    parameter int                 RF_DEPTH  = 512,
    parameter int                 FIELD_W   = 7,
    parameter logic [FIELD_W-1:0] NULL_CODE = 7'h7F,
    parameter int                 LEN_W     = $clog2(RF_DEPTH) + 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_finish,
    input  logic [2:0][FIELD_W-1:0]      i_RF [0:RF_DEPTH-1],
    input  logic [LEN_W-1:0]             i_length,
    output logic                         o_busy,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [FIELD_W-1:0]           o_x,
    output logic [FIELD_W-1:0]           o_y,
    output logic [FIELD_W-1:0]           o_idx,
    output logic                         o_done,
    output logic [LEN_W-1:0]             o_emit_cnt
);

    // Index width for the RF read port; ptr carries one extra bit so it can
    // reach len_q == RF_DEPTH without wrapping.
    localparam int IDX_W = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(RF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t                  state;
    logic [LEN_W-1:0]        ptr;
    logic [LEN_W-1:0]        len_q;
    logic [IDX_W-1:0]        rd_idx;
    logic [2:0][FIELD_W-1:0] cur_entry;
    logic                    cur_null;
    logic                    handshake;
    logic                    slot_free;
    logic [LEN_W-1:0]        len_clamped;

    // Current RF entry, null decode, handshake and slot-free conditions.
    always_comb begin
        rd_idx      = ptr[IDX_W-1:0];
        cur_entry   = i_RF[rd_idx];
        cur_null    = (cur_entry[0] == NULL_CODE);
        handshake   = o_valid && i_ready;
        slot_free   = !o_valid || i_ready;
        len_clamped = (i_length > DEPTH_L) ? DEPTH_L : i_length;
    end

    // Scan FSM with registered outputs: a new triple can be loaded in the
    // same cycle the previous one is accepted, giving one triple per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            len_q      <= '0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_x        <= '0;
            o_y        <= '0;
            o_idx      <= '0;
            o_done     <= 1'b0;
            o_emit_cnt <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_finish) begin
                        ptr        <= '0;
                        o_emit_cnt <= '0;
                        len_q      <= len_clamped;
                        if (i_length == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state  <= SCAN;
                            o_busy <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (handshake) begin
                        o_emit_cnt <= o_emit_cnt + 1'b1;
                    end
                    if (slot_free) begin
                        if (ptr < len_q) begin
                            ptr <= ptr + 1'b1;
                            if (cur_null) begin
                                o_valid <= 1'b0;
                            end else begin
                                o_valid <= 1'b1;
                                o_x     <= cur_entry[0];
                                o_y     <= cur_entry[1];
                                o_idx   <= cur_entry[2];
                            end
                        end else begin
                            o_valid <= 1'b0;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_addr_dispatcher.sv
// tb_rf_addr_dispatcher
// Directed and randomized passes over a bench-owned RF image. The expected
// stream is the ordered list of non-null entries in the clamped length,
// and latencies follow from counting one cycle per scanned entry.

module tb_rf_addr_dispatcher;

    localparam int RF_DEPTH = 512;
    localparam int FIELD_W  = 7;
    localparam int LEN_W    = $clog2(RF_DEPTH) + 1;

    typedef logic [2:0][FIELD_W-1:0] entry_t;

    logic               i_clk    = 1'b0;
    logic               i_rst_n  = 1'b0;
    logic               i_finish = 1'b0;
    logic               i_ready  = 1'b0;
    logic [LEN_W-1:0]   i_length = '0;
    entry_t             rf [0:RF_DEPTH-1];
    logic               o_busy;
    logic               o_valid;
    logic [FIELD_W-1:0] o_x;
    logic [FIELD_W-1:0] o_y;
    logic [FIELD_W-1:0] o_idx;
    logic               o_done;
    logic [LEN_W-1:0]   o_emit_cnt;

    int total = 0;
    int bad   = 0;
    entry_t expq [$];

    // Free-running clock, period 10.
    always #5 i_clk = ~i_clk;

    rf_addr_dispatcher #(
        .RF_DEPTH (RF_DEPTH),
        .FIELD_W  (FIELD_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_finish   (i_finish),
        .i_RF       (rf),
        .i_length   (i_length),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_x        (o_x),
        .o_y        (o_y),
        .o_idx      (o_idx),
        .o_done     (o_done),
        .o_emit_cnt (o_emit_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fillDense();
        for (int i = 0; i < RF_DEPTH; i++) begin
            rf[i][0] = 7'(i % 8);
            rf[i][1] = 7'(i % 128);
            rf[i][2] = 7'((3 * i) % 128);
        end
    endtask

    task automatic fillRandom(input int null_pct);
        for (int i = 0; i < RF_DEPTH; i++) begin
            rf[i][0] = ($urandom_range(0, 99) < null_pct) ? 7'h7F : 7'($urandom_range(0, 126));
            rf[i][1] = 7'($urandom_range(0, 127));
            rf[i][2] = 7'($urandom_range(0, 127));
        end
    endtask

    // One pass: mode 0 = ready always high, 1 = ready low on cycles 2..6,
    // 2 = random ready. retrig_k re-pulses i_finish on that cycle, abort_after
    // asserts reset once that many handshakes are done, collide pulses
    // i_finish in the o_done cycle.
    task automatic applyStimulus(input int len, input int mode, input int retrig_k,
                                 input int abort_after, input bit collide);
        int     scan;
        int     first_nn;
        int     n_exp;
        int     k;
        int     hs;
        int     vcount;
        int     first_v;
        int     done_k;
        int     last_hs;
        bit     prev_stall;
        entry_t prev;
        entry_t exp_e;
        scan     = (len > RF_DEPTH) ? RF_DEPTH : len;
        first_nn = -1;
        expq.delete();
        for (int i = 0; i < scan; i++) begin
            if (rf[i][0] != 7'h7F) begin
                if (first_nn < 0) first_nn = i;
                expq.push_back(rf[i]);
            end
        end
        n_exp      = expq.size();
        k          = 0;
        hs         = 0;
        vcount     = 0;
        first_v    = -1;
        done_k     = -1;
        last_hs    = -1;
        prev_stall = 1'b0;
        prev       = '0;
        @(negedge i_clk);
        i_length = LEN_W'(len);
        i_finish = 1'b1;
        i_ready  = (mode != 1);
        while (k < 2000 && done_k < 0) begin
            @(negedge i_clk);
            k++;
            i_finish = (k == retrig_k);
            if (abort_after > 0 && hs == abort_after) begin
                checkOutput("emit_before_rst", 32'(o_emit_cnt), 32'(abort_after));
                i_finish = 1'b0;
                i_rst_n  = 1'b0;
                #1;
                checkOutput("rst_valid", 32'(o_valid), 0);
                checkOutput("rst_busy", 32'(o_busy), 0);
                checkOutput("rst_done", 32'(o_done), 0);
                checkOutput("rst_emit", 32'(o_emit_cnt), 0);
                checkOutput("rst_data", 32'({o_idx, o_y, o_x}), 0);
                return;
            end
            if (k == 1) begin
                checkOutput("busy_k1", 32'(o_busy), 32'(scan != 0));
                checkOutput("emit_clear", 32'(o_emit_cnt), 0);
            end
            if (prev_stall) begin
                checkOutput("hold_valid", 32'(o_valid), 1);
                checkOutput("hold_data", 32'({o_idx, o_y, o_x}), 32'(prev));
            end
            if (o_done) begin
                done_k = k;
                checkOutput("busy_at_done", 32'(o_busy), 0);
                checkOutput("valid_at_done", 32'(o_valid), 0);
                if (collide) i_finish = 1'b1;
            end
            case (mode)
                0:       i_ready = 1'b1;
                1:       i_ready = !(k >= 2 && k <= 6);
                default: i_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (o_valid) begin
                vcount++;
                if (first_v < 0) first_v = k;
            end
            if (o_valid && i_ready && done_k < 0) begin
                hs++;
                last_hs = k;
                if (expq.size() == 0) begin
                    checkOutput("extra_emit", 32'(hs), 32'(n_exp));
                end else begin
                    exp_e = expq.pop_front();
                    checkOutput("triple", 32'({o_idx, o_y, o_x}), 32'(exp_e));
                end
            end
            prev_stall = o_valid && !i_ready;
            prev       = {o_idx, o_y, o_x};
        end
        checkOutput("done_seen", 32'(done_k > 0), 1);
        checkOutput("left_over", 32'(expq.size()), 0);
        checkOutput("hs_count", 32'(hs), 32'(n_exp));
        checkOutput("emit_cnt", 32'(o_emit_cnt), 32'(n_exp));
        if (scan == 0) begin
            checkOutput("done_lat_zero", 32'(done_k), 1);
            checkOutput("valid_zero", 32'(vcount), 0);
        end else if (rf[scan-1][0] != 7'h7F) begin
            checkOutput("done_after_hs", 32'(done_k), 32'(last_hs + 1));
        end
        if (n_exp > 0) checkOutput("first_valid", 32'(first_v), 32'(2 + first_nn));
        if (mode == 0 && scan > 0) begin
            checkOutput("done_lat", 32'(done_k), 32'(scan + 2));
            checkOutput("valid_cnt", 32'(vcount), 32'(n_exp));
        end
        @(negedge i_clk);
        i_finish = 1'b0;
        checkOutput("done_pulse", 32'(o_done), 0);
        checkOutput("busy_after", 32'(o_busy), 0);
        checkOutput("emit_hold", 32'(o_emit_cnt), 32'(n_exp));
        if (collide) begin
            @(negedge i_clk);
            checkOutput("collide_busy", 32'(o_busy), 0);
            checkOutput("collide_done", 32'(o_done), 0);
        end
    endtask

    // Directed sequence of passes followed by the summary.
    initial begin
        fillDense();
        repeat (3) @(negedge i_clk);
        checkOutput("reset_valid", 32'(o_valid), 0);
        checkOutput("reset_busy", 32'(o_busy), 0);
        checkOutput("reset_done", 32'(o_done), 0);
        checkOutput("reset_emit", 32'(o_emit_cnt), 0);
        checkOutput("reset_data", 32'({o_idx, o_y, o_x}), 0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        $display("[TB] dense pass");
        applyStimulus(474, 0, 0, 0, 1'b0);

        $display("[TB] null skipping");
        fillRandom(0);
        rf[1][0] = 7'h7F;
        rf[4][0] = 7'h7F;
        applyStimulus(6, 0, 0, 0, 1'b0);

        $display("[TB] backpressure with finish at done");
        fillRandom(0);
        applyStimulus(3, 1, 0, 0, 1'b1);

        $display("[TB] zero length");
        applyStimulus(0, 0, 0, 0, 1'b0);

        $display("[TB] clamped length");
        fillDense();
        applyStimulus(600, 0, 0, 0, 1'b0);

        $display("[TB] random passes");
        for (int r = 0; r < 3; r++) begin
            fillRandom(25);
            applyStimulus(int'($urandom_range(1, 520)), 2, 0, 0, 1'b0);
        end

        $display("[TB] re-trigger during scan");
        fillRandom(20);
        applyStimulus(40, 2, 5, 0, 1'b0);

        $display("[TB] reset mid-pass");
        fillDense();
        applyStimulus(474, 0, 0, 10, 1'b0);
        repeat (3) begin
            @(negedge i_clk);
            checkOutput("rst_no_done", 32'(o_done), 0);
            checkOutput("rst_no_valid", 32'(o_valid), 0);
        end
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        $display("[TB] clean pass after reset");
        fillRandom(15);
        applyStimulus(20, 0, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
